// File: rtl/video_timing_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : video_timing_meter
// Description : Measures line length, active width, lines per frame and active
//               lines from a cleaned sync/blank stream. Locks after a run of
//               identical frames.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_meter #(
    parameter int HCNT_W        = 12,
    parameter int VCNT_W        = 11,
    parameter int STABLE_FRAMES = 4
) (
    input  logic              clk_vid,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              HSync,
    input  logic              VSync,
    input  logic              HBlank,
    input  logic              VBlank,
    output logic [HCNT_W-1:0] h_total,
    output logic [HCNT_W-1:0] h_active,
    output logic [VCNT_W-1:0] v_total,
    output logic [VCNT_W-1:0] v_active,
    output logic              mode_valid,
    output logic              mode_changed
);

    localparam int MATCH_W = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t state, next_state;

    logic              hs_prev, vs_prev;
    logic [HCNT_W-1:0] hcnt, acnt;
    logic [VCNT_W-1:0] vcnt, vacnt;
    logic [HCNT_W-1:0] frame_hlen, frame_hmax;
    logic              frame_irreg;
    logic [HCNT_W-1:0] cand_hlen, cand_hmax;
    logic [VCNT_W-1:0] cand_vtot, cand_vact;
    logic [MATCH_W-1:0] match_cnt, next_match, match_inc;

    logic              hs_rise, vs_rise, pix_act, first_line, timeout;
    logic [HCNT_W-1:0] line_len, line_act;
    logic [VCNT_W-1:0] vcnt_inc, vacnt_inc;
    logic [HCNT_W-1:0] f_hlen, f_hmax;
    logic [VCNT_W-1:0] f_vcnt, f_vacnt;
    logic              f_irreg, tuple_eq;
    logic              load_cand, lock_now, changed;
    logic [HCNT_W-1:0] cn_hlen, cn_hmax;
    logic [VCNT_W-1:0] cn_vtot, cn_vact;

    assign hs_rise = ce_pix & HSync & ~hs_prev;
    assign vs_rise = ce_pix & VSync & ~vs_prev;
    assign pix_act = ~HBlank & ~VBlank;
    assign timeout = (hcnt == '1) || (vcnt == '1);

    // Line measurements include the current ce; all counters saturate.
    assign line_len  = (hcnt == '1) ? hcnt : hcnt + 1'b1;
    assign line_act  = (pix_act && acnt != '1) ? acnt + 1'b1 : acnt;
    assign vcnt_inc  = (vcnt == '1) ? vcnt : vcnt + 1'b1;
    assign vacnt_inc = (vacnt == '1) ? vacnt : vacnt + 1'b1;
    assign match_inc = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;

    // Frame tuple as it stands after this ce: a coincident HS line is counted first.
    assign first_line = (vcnt == '0);
    assign f_vcnt  = hs_rise ? vcnt_inc : vcnt;
    assign f_vacnt = (hs_rise && line_act != '0) ? vacnt_inc : vacnt;
    assign f_hmax  = (hs_rise && line_act > frame_hmax) ? line_act : frame_hmax;
    assign f_hlen  = (hs_rise && first_line) ? line_len : frame_hlen;
    assign f_irreg = frame_irreg | (hs_rise && !first_line && line_len != frame_hlen);

    assign tuple_eq = (f_hlen == cand_hlen) && (f_hmax == cand_hmax) &&
                      (f_vcnt == cand_vtot) && (f_vacnt == cand_vact);

    assign cn_hlen = load_cand ? f_hlen  : cand_hlen;
    assign cn_hmax = load_cand ? f_hmax  : cand_hmax;
    assign cn_vtot = load_cand ? f_vcnt  : cand_vtot;
    assign cn_vact = load_cand ? f_vacnt : cand_vact;

    always_comb begin
        next_state = state;
        next_match = match_cnt;
        load_cand  = 1'b0;
        lock_now   = 1'b0;
        changed    = 1'b0;
        if (timeout) begin
            next_state = ST_IDLE;
            next_match = '0;
            changed    = (state == ST_LOCKED);
        end else if (vs_rise) begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_MEASURE;
                    next_match = '0;
                end
                ST_MEASURE: begin
                    if (f_irreg) begin
                        next_match = '0;
                    end else begin
                        if (tuple_eq && match_cnt != '0) begin
                            next_match = match_inc;
                        end else begin
                            load_cand  = 1'b1;
                            next_match = MATCH_W'(1);
                        end
                        if (next_match >= MATCH_LOCK) begin
                            lock_now   = 1'b1;
                            next_state = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (f_irreg || !tuple_eq) begin
                        changed    = 1'b1;
                        next_state = ST_MEASURE;
                        if (f_irreg) begin
                            next_match = '0;
                        end else begin
                            load_cand  = 1'b1;
                            next_match = MATCH_W'(1);
                        end
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    next_match = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
        end else begin
            state     <= next_state;
            match_cnt <= next_match;
        end
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            hcnt         <= '0;
            acnt         <= '0;
            vcnt         <= '0;
            vacnt        <= '0;
            frame_hlen   <= '0;
            frame_hmax   <= '0;
            frame_irreg  <= 1'b0;
            cand_hlen    <= '0;
            cand_hmax    <= '0;
            cand_vtot    <= '0;
            cand_vact    <= '0;
            h_total      <= '0;
            h_active     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            mode_valid   <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode_valid   <= (next_state == ST_LOCKED);
            mode_changed <= changed;
            if (timeout) begin
                if (ce_pix) begin
                    hs_prev <= HSync;
                    vs_prev <= VSync;
                end
                hcnt        <= '0;
                acnt        <= '0;
                vcnt        <= '0;
                vacnt       <= '0;
                frame_hlen  <= '0;
                frame_hmax  <= '0;
                frame_irreg <= 1'b0;
            end else if (ce_pix) begin
                hs_prev <= HSync;
                vs_prev <= VSync;
                hcnt    <= hs_rise ? '0 : line_len;
                acnt    <= hs_rise ? '0 : line_act;
                frame_hlen <= f_hlen;
                if (vs_rise) begin
                    vcnt        <= '0;
                    vacnt       <= '0;
                    frame_hmax  <= '0;
                    frame_irreg <= 1'b0;
                end else begin
                    vcnt        <= f_vcnt;
                    vacnt       <= f_vacnt;
                    frame_hmax  <= f_hmax;
                    frame_irreg <= f_irreg;
                end
            end
            if (load_cand) begin
                cand_hlen <= f_hlen;
                cand_hmax <= f_hmax;
                cand_vtot <= f_vcnt;
                cand_vact <= f_vacnt;
            end
            if (lock_now) begin
                h_total  <= cn_hlen;
                h_active <= cn_hmax;
                v_total  <= cn_vtot;
                v_active <= cn_vact;
            end
        end
    end

endmodule
`default_nettype wire
